// File: rtl/mem_access.sv
// Memory-access stage: ALU pass-through or load/store over a request/response data bus.
// Optional MEM_MISALIGN_CHECK_EN makes misaligned accesses skip the bus and flag out_misalign.
module mem_access (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_memop,
   input  logic [2:0]  in_size,
   input  logic [63:0] in_alu,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        dreq_valid,
   output logic [63:0] dreq_addr,
   output logic        dreq_write,
   output logic [7:0]  dreq_strobe,
   output logic [63:0] dreq_wdata,
   input  logic        dresp_ok,
   input  logic [63:0] dresp_data,
   output logic        out_valid,
   output logic [63:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic        out_misalign
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [2:0] size_q;
   logic       load_q;

   logic       take, is_ld, is_st, mis;
   logic [5:0] lane_sh;
   logic [7:0] base_strobe, strobe_c;
   logic [63:0] wdata_c;

   assign in_ready   = (state == IDLE) || (state == DONE);
   assign dreq_valid = (state == REQ);
   assign out_valid  = (state == DONE);

   assign take    = in_valid && in_ready;
   assign is_ld   = (in_memop == 2'b01);
   assign is_st   = (in_memop == 2'b10);
   assign lane_sh = {in_alu[2:0], 3'b000};

   always_comb begin
      base_strobe = 8'h00;
      case (in_size[1:0])
         2'b00:   base_strobe = 8'h01;
         2'b01:   base_strobe = 8'h03;
         2'b10:   base_strobe = 8'h0F;
         default: base_strobe = 8'hFF;
      endcase
   end

   // Lanes shifted past byte 7 fall off the 8-bit / 64-bit results.
   assign strobe_c = base_strobe << in_alu[2:0];
   assign wdata_c  = in_wdata << lane_sh;

`ifdef MEM_MISALIGN_CHECK_EN
   logic mis_addr;
   always_comb begin
      mis_addr = 1'b0;
      case (in_size[1:0])
         2'b01:   mis_addr = in_alu[0];
         2'b10:   mis_addr = |in_alu[1:0];
         2'b11:   mis_addr = |in_alu[2:0];
         default: mis_addr = 1'b0;
      endcase
   end
   assign mis = (is_ld || is_st) && mis_addr;
`else
   assign mis = 1'b0;
`endif

   // Size code: [1:0] selects width (reserved 111 lands on D), [2] selects zero-extend.
   function automatic logic [63:0] load_extract(input logic [63:0] data,
                                                input logic [2:0]  off,
                                                input logic [2:0]  sz);
      logic [63:0] sh;
      sh = data >> {off, 3'b000};
      case (sz[1:0])
         2'b00:   load_extract = sz[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         2'b01:   load_extract = sz[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         2'b10:   load_extract = sz[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: load_extract = sh;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         size_q       <= 3'd0;
         load_q       <= 1'b0;
         dreq_addr    <= 64'd0;
         dreq_write   <= 1'b0;
         dreq_strobe  <= 8'd0;
         dreq_wdata   <= 64'd0;
         out_data     <= 64'd0;
         out_rd       <= 5'd0;
         out_wen      <= 1'b0;
         out_misalign <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               if (dresp_ok) begin
                  state <= DONE;
                  if (load_q)
                     out_data <= load_extract(dresp_data, dreq_addr[2:0], size_q);
               end
            end
            default: begin
               if (take) begin
                  out_rd <= in_rd;
                  if ((is_ld || is_st) && !mis) begin
                     state        <= REQ;
                     size_q       <= in_size;
                     load_q       <= is_ld;
                     dreq_addr    <= in_alu;
                     dreq_write   <= is_st;
                     dreq_strobe  <= is_st ? strobe_c : 8'd0;
                     dreq_wdata   <= is_st ? wdata_c : 64'd0;
                     out_data     <= 64'd0;
                     out_wen      <= is_ld;
                     out_misalign <= 1'b0;
                  end else begin
                     state        <= DONE;
                     out_data     <= in_alu;
                     out_wen      <= !mis;
                     out_misalign <= mis;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against an arithmetic reference model.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_memop;
   logic [2:0]  in_size;
   logic [63:0] in_alu;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic        dreq_write;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_wdata;
   logic        dresp_ok;
   logic [63:0] dresp_data;
   logic        out_valid;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_misalign;

   int errors = 0;
   int checks = 0;
   logic [63:0] last_data;
   logic [7:0]  last_strobe;
   logic [63:0] last_wdata;
   logic        last_mis;

   mem_access dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_memop(in_memop), .in_size(in_size),
      .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
      .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
      .dresp_ok(dresp_ok), .dresp_data(dresp_data),
      .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
      .out_wen(out_wen), .out_misalign(out_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model, written from the access rules with plain arithmetic.
   function automatic int nbytes(input logic [2:0] sz);
      return 1 << sz[1:0];
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] data, input logic [63:0] addr,
                                            input logic [2:0] sz);
      int n = nbytes(sz);
      logic [63:0] mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 1);
      logic [63:0] v = (data >> (8 * (addr % 8))) & mask;
      if (!sz[2] && n < 8 && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] ref_strobe(input logic [63:0] addr, input logic [2:0] sz);
      int s = ((1 << nbytes(sz)) - 1) << (addr % 8);
      return s[7:0];
   endfunction

   function automatic logic ref_mis(input logic [1:0] op, input logic [63:0] addr,
                                    input logic [2:0] sz);
`ifdef MEM_MISALIGN_CHECK_EN
      return (op == 2'b01 || op == 2'b10) && ((addr % nbytes(sz)) != 0);
`else
      return 1'b0;
`endif
   endfunction

   // Entered and left at a negedge with the DUT able to accept.
   task automatic do_op(input logic [1:0] op, input logic [2:0] sz, input logic [63:0] alu,
                        input logic [63:0] wd, input logic [4:0] rd, input int wt,
                        input logic [63:0] rdata);
      logic mis = ref_mis(op, alu, sz);
      logic mem = (op == 2'b01 || op == 2'b10) && !mis;
      logic [63:0] exp_data;
      logic exp_wen;
      chk("in_ready_before", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1; in_memop = op; in_size = sz; in_alu = alu; in_wdata = wd; in_rd = rd;
      @(negedge clk);
      in_valid = 1'b0;
      in_memop = 2'($urandom); in_alu = {$urandom, $urandom};
      if (!mem) begin
         exp_data = alu;
         exp_wen  = !mis;
      end else begin
         for (int k = 0; k <= wt; k++) begin
            chk("dreq_valid", {63'd0, dreq_valid}, 64'd1);
            chk("in_ready_req", {63'd0, in_ready}, 64'd0);
            chk("out_valid_req", {63'd0, out_valid}, 64'd0);
            chk("dreq_addr", dreq_addr, alu);
            chk("dreq_write", {63'd0, dreq_write}, {63'd0, op == 2'b10});
            chk("dreq_strobe", {56'd0, dreq_strobe},
                {56'd0, (op == 2'b10) ? ref_strobe(alu, sz) : 8'd0});
            if (op == 2'b10) chk("dreq_wdata", dreq_wdata, wd << (8 * (alu % 8)));
            last_strobe = dreq_strobe;
            last_wdata  = dreq_wdata;
            if (k == wt) begin dresp_ok = 1'b1; dresp_data = rdata; end
            else dresp_data = {$urandom, $urandom};
            @(negedge clk);
         end
         dresp_ok = 1'b0;
         exp_data = (op == 2'b01) ? ref_load(rdata, alu, sz) : 64'd0;
         exp_wen  = (op == 2'b01);
      end
      chk("dreq_valid_done", {63'd0, dreq_valid}, 64'd0);
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_data", out_data, exp_data);
      chk("out_rd", {59'd0, out_rd}, {59'd0, rd});
      chk("out_wen", {63'd0, out_wen}, {63'd0, exp_wen});
      chk("out_misalign", {63'd0, out_misalign}, {63'd0, mis});
      last_data = out_data;
      last_mis  = out_misalign;
   endtask

   task automatic idle_cycle(input logic stray_resp);
      dresp_ok = stray_resp;
      dresp_data = {$urandom, $urandom};
      @(negedge clk);
      dresp_ok = 1'b0;
      chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
      chk("idle_dreq_valid", {63'd0, dreq_valid}, 64'd0);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_memop = 2'b00; in_size = 3'd0; in_alu = '0;
      in_wdata = '0; in_rd = '0; dresp_ok = 1'b0; dresp_data = '0;
      last_data = '0; last_strobe = '0; last_wdata = '0; last_mis = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_dreq_addr", dreq_addr, 64'd0);
      chk("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      reset = 1'b0;

      // Reset in the middle of a bus request
      in_valid = 1'b1; in_memop = 2'b01; in_size = 3'b011; in_alu = 64'h5000; in_rd = 5'd7;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_dreq_valid", {63'd0, dreq_valid}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstreq_dreq_valid", {63'd0, dreq_valid}, 64'd0);
      chk("rstreq_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rstreq_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rstreq_dreq_addr", dreq_addr, 64'd0);
      idle_cycle(1'b1);
      idle_cycle(1'b0);

      // Back-to-back pass-through
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_memop = 2'b00; in_alu = 64'(i); in_rd = 5'(i);
         @(negedge clk);
         chk("pt_out_valid", {63'd0, out_valid}, 64'd1);
         chk("pt_out_data", out_data, 64'(i));
         chk("pt_out_wen", {63'd0, out_wen}, 64'd1);
      end
      in_valid = 1'b0;
      idle_cycle(1'b0);

      do_op(2'b01, 3'b000, 64'h1003, 64'd0, 5'd1, 3, 64'h00000000_80000000);
      chk("lb_value", last_data, 64'hFFFFFFFF_FFFFFF80);
      idle_cycle(1'b0);
      do_op(2'b01, 3'b110, 64'h2004, 64'd0, 5'd2, 0, 64'hDEADBEEF_00000000);
      chk("lwu_value", last_data, 64'h00000000_DEADBEEF);
      do_op(2'b10, 3'b001, 64'h3006, 64'h1234, 5'd3, 1, 64'd0);
      chk("sh_strobe", {56'd0, last_strobe}, 64'hC0);
      chk("sh_wdata", last_wdata, 64'h1234_0000_0000_0000);
      do_op(2'b10, 3'b010, 64'h4002, 64'hAABBCCDD, 5'd4, 0, 64'd0);
`ifdef MEM_MISALIGN_CHECK_EN
      chk("sw_mis_flag", {63'd0, last_mis}, 64'd1);
`else
      chk("sw_mis_strobe", {56'd0, last_strobe}, 64'h3C);
`endif
      idle_cycle(1'b1);

      for (int n = 0; n < 300; n++) begin
         logic [63:0] a = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) a[63:8] = '0;
         do_op(2'($urandom), 3'($urandom), a, {$urandom, $urandom}, 5'($urandom),
               $urandom_range(0, 3), {$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
